// File: rtl/bsg_mesh_router_wormhole_output_sched.sv
// Per-output-port wormhole scheduler for the mesh/ruche router.
// Selects one requesting input using round-robin arbitration and holds that
// input until its whole packet has been sent. It drives the crossbar select and
// the dequeue (yumi) of the granted input FIFO.
// Optional build macro BSG_MESH_ROUTER_SCHED_STALL_CNT_EN adds two counters:
// a stall counter (output valid but downstream not ready) and a
// head-of-line bubble counter.
module bsg_mesh_router_wormhole_output_sched #(
    parameter int num_in_p        = 5,
    parameter int len_width_p     = 4,
    parameter int sel_id_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [num_in_p-1:0]             v_i,
    input  logic [num_in_p-1:0]             req_i,
    input  logic [num_in_p*len_width_p-1:0] len_i,
    input  logic                            ready_and_i,
    output logic                            v_o,
    output logic [num_in_p-1:0]             sel_o,
    output logic [sel_id_width_lp-1:0]      sel_id_o,
    output logic [num_in_p-1:0]             yumi_o,
    output logic                            locked_o
`ifdef BSG_MESH_ROUTER_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]                     stall_cnt_o,
    output logic [31:0]                     hol_cnt_o
`endif
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                     state, state_n;
    logic [sel_id_width_lp-1:0] rr_ptr, rr_ptr_n;
    logic [sel_id_width_lp-1:0] owner, owner_n;
    logic [len_width_p-1:0]     len_cnt, len_cnt_n;

    logic [num_in_p-1:0]        cand;
    logic                       grant_found;
    logic [sel_id_width_lp-1:0] grant_id;
    logic [len_width_p-1:0]     grant_len;
    int                         scan_idx;
    logic                       xfer;

    // The pointer wraps by an explicit compare. num_in_p need not be a power of two.
    function automatic logic [sel_id_width_lp-1:0] next_ptr(input logic [sel_id_width_lp-1:0] p);
        return (p == sel_id_width_lp'(num_in_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scan of the candidates, starting at rr_ptr.
    always_comb begin
        cand        = v_i & req_i;
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int i = 0; i < num_in_p; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= num_in_p) scan_idx = scan_idx - num_in_p;
            if (!grant_found && cand[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = sel_id_width_lp'(scan_idx);
            end
        end
        grant_len = len_i[int'(grant_id)*len_width_p +: len_width_p];
    end

    // Outputs. A held packet selects only its owner. All outputs are forced low during reset.
    always_comb begin
        v_o      = 1'b0;
        sel_o    = '0;
        sel_id_o = '0;
        locked_o = 1'b0;
        if (!reset_i) begin
            if (state == LOCKED) begin
                v_o      = v_i[owner];
                sel_o    = num_in_p'(1) << owner;
                sel_id_o = owner;
                locked_o = 1'b1;
            end else begin
                v_o      = grant_found;
                sel_o    = grant_found ? (num_in_p'(1) << grant_id) : '0;
                sel_id_o = grant_id;
            end
        end
        xfer   = v_o & ready_and_i;
        yumi_o = xfer ? sel_o : '0;
    end

    // Next-state logic. The pointer advances only when a packet completes.
    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        owner_n   = owner;
        len_cnt_n = len_cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (grant_len == '0) begin
                        rr_ptr_n = next_ptr(grant_id);
                    end else begin
                        state_n   = LOCKED;
                        owner_n   = grant_id;
                        len_cnt_n = grant_len;
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    len_cnt_n = len_cnt - 1'b1;
                    if (len_cnt == len_width_p'(1)) begin
                        state_n  = IDLE;
                        rr_ptr_n = next_ptr(owner);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register. Reset drops any packet in flight immediately.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            len_cnt <= '0;
        end else begin
            state   <= state_n;
            rr_ptr  <= rr_ptr_n;
            owner   <= owner_n;
            len_cnt <= len_cnt_n;
        end
    end

`ifdef BSG_MESH_ROUTER_SCHED_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // Saturating counters: downstream stalls, and bubbles from the owner while locked.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_o <= '0;
            hol_cnt_o   <= '0;
        end else begin
            if (v_o && !ready_and_i)             stall_cnt_o <= sat_inc(stall_cnt_o);
            if (state == LOCKED && !v_i[owner])  hol_cnt_o   <= sat_inc(hol_cnt_o);
        end
    end
`endif

`ifndef SYNTHESIS
    // Sanity checks: at most one dequeue per cycle, and only from a valid FIFO.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert ($countones(yumi_o) <= 1);
            assert ((yumi_o & ~v_i) == '0);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mesh_router_wormhole_output_sched.sv
// Testbench for bsg_mesh_router_wormhole_output_sched.
// The reference model keeps packet state as plain integers and chooses the
// grant by the smallest modular distance from the round-robin pointer.
// Directed scenarios add literal expectations. A random phase follows.
module tb_bsg_mesh_router_wormhole_output_sched;

    localparam int N = 5;
    localparam int LW = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  v;
    logic [N-1:0]  req;
    logic [N*LW-1:0] len_vec;
    logic          rdy;
    logic          v_o;
    logic [N-1:0]  sel_o;
    logic [2:0]    sel_id_o;
    logic [N-1:0]  yumi_o;
    logic          locked_o;
`ifdef BSG_MESH_ROUTER_SCHED_STALL_CNT_EN
    logic [31:0]   stall_cnt_o;
    logic [31:0]   hol_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    bsg_mesh_router_wormhole_output_sched #(.num_in_p(N), .len_width_p(LW)) dut (
        .clk_i(clk),
        .reset_i(rst),
        .v_i(v),
        .req_i(req),
        .len_i(len_vec),
        .ready_and_i(rdy),
        .v_o(v_o),
        .sel_o(sel_o),
        .sel_id_o(sel_id_o),
        .yumi_o(yumi_o),
        .locked_o(locked_o)
`ifdef BSG_MESH_ROUTER_SCHED_STALL_CNT_EN
        ,
        .stall_cnt_o(stall_cnt_o),
        .hol_cnt_o(hol_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model state
    bit  m_locked = 0;
    int  m_owner = 0;
    int  m_rem = 0;
    int  m_rr = 0;
    longint m_stall = 0;
    longint m_hol = 0;

    logic         e_v;
    logic [N-1:0] e_sel;
    int           e_gid;
    int           e_best;
    logic         e_locked;
    logic         e_xfer;
    int           e_len;

    // The expected outputs come from the model state and the current inputs.
    always_comb begin
        e_v = 1'b0;
        e_sel = '0;
        e_gid = 0;
        e_best = N;
        e_locked = 1'b0;
        if (!rst) begin
            if (m_locked) begin
                e_locked = 1'b1;
                e_gid = m_owner;
                e_v = v[m_owner];
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (v[i] && req[i] && ((i - m_rr + N) % N) < e_best) begin
                        e_best = (i - m_rr + N) % N;
                        e_gid = i;
                        e_v = 1'b1;
                    end
                end
            end
            if (m_locked || e_v) e_sel = N'(1) << e_gid;
        end
        e_xfer = e_v & rdy;
        e_len = int'(len_vec[e_gid*LW +: LW]);
    end

    // The model advances on each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            m_locked <= 0; m_owner <= 0; m_rem <= 0; m_rr <= 0;
            m_stall <= 0; m_hol <= 0;
        end else begin
            if (e_v && !rdy && m_stall < 64'hFFFF_FFFF) m_stall <= m_stall + 1;
            if (m_locked && !v[m_owner] && m_hol < 64'hFFFF_FFFF) m_hol <= m_hol + 1;
            if (e_xfer) begin
                if (m_locked) begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        m_locked <= 0;
                        m_rr <= (m_owner + 1) % N;
                    end
                end else if (e_len == 0) begin
                    m_rr <= (e_gid + 1) % N;
                end else begin
                    m_locked <= 1;
                    m_owner <= e_gid;
                    m_rem <= e_len;
                end
            end
        end
    end

    // Compare the DUT against the model on every cycle, away from the clock edge.
    always @(negedge clk) begin
        chk("v_o", v_o, e_v);
        chk("sel_o", sel_o, e_sel);
        chk("yumi_o", yumi_o, e_xfer ? e_sel : '0);
        chk("locked_o", locked_o, e_locked);
        if (e_sel != '0) chk("sel_id_o", sel_id_o, e_gid);
`ifdef BSG_MESH_ROUTER_SCHED_STALL_CNT_EN
        chk("stall_cnt_o", stall_cnt_o, m_stall);
        chk("hol_cnt_o", hol_cnt_o, m_hol);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int l);
        len_vec[i*LW +: LW] = LW'(l);
    endtask

    task automatic do_reset();
        rst = 1'b1; v = '0; req = '0; len_vec = '0; rdy = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int rr_exp [5] = '{0, 2, 4, 0, 2};

    initial begin
        rst = 1'b1; v = 5'b11111; req = 5'b11111; len_vec = '0; rdy = 1'b1;
        tick(); tick();
        chk("reset_v_o", v_o, 0);
        chk("reset_yumi", yumi_o, 0);
        chk("reset_locked", locked_o, 0);
        rst = 1'b0;

        // Single-flit round robin
        v = 5'b10101; req = 5'b10101; len_vec = '0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_sel_id", sel_id_o, rr_exp[k]);
            chk("rr_yumi", yumi_o, 1 << rr_exp[k]);
            tick();
        end

        // Wormhole lock: input 1 len 3 against input 3
        do_reset();
        v = 5'b01010; req = 5'b01010; set_len(1, 3); set_len(3, 0);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("worm_sel_id", sel_id_o, 1);
            chk("worm_locked", locked_o, (k > 0) ? 1 : 0);
            tick();
        end
        chk("worm_next_sel_id", sel_id_o, 3);
        chk("worm_next_locked", locked_o, 0);
        tick();

        // Backpressure mid-packet
        do_reset();
        v = 5'b00100; req = 5'b00100; set_len(2, 2);
        tick(); tick();
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_v_o", v_o, 1);
            chk("bp_yumi", yumi_o, 0);
            chk("bp_locked", locked_o, 1);
            tick();
        end
        rdy = 1'b1;
        #1;
        chk("bp_last_yumi", yumi_o, 5'b00100);
        tick();
        #1;
        chk("bp_idle_locked", locked_o, 0);

        // Bubble in packet while input 0 requests
        do_reset();
        v = 5'b00100; req = 5'b00100; set_len(2, 3);
        tick(); tick();
        v = 5'b00001; req = 5'b00001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bub_v_o", v_o, 0);
            chk("bub_yumi", yumi_o, 0);
            chk("bub_locked", locked_o, 1);
            tick();
        end
        v = 5'b00101;
        tick(); tick();
        #1;
        chk("bub_after_locked", locked_o, 0);
        chk("bub_after_sel_id", sel_id_o, 0);
`ifdef BSG_MESH_ROUTER_SCHED_STALL_CNT_EN
        chk("bub_hol_cnt", hol_cnt_o, 3);
`endif

        // Wrap-around of the pointer
        do_reset();
        v = 5'b01000; req = 5'b01000;
        #1; chk("wrap_g3", sel_id_o, 3);
        tick();
        v = 5'b00001; req = 5'b00001;
        #1; chk("wrap_g0", sel_id_o, 0);
        tick();
        v = 5'b00011; req = 5'b00011;
        #1; chk("wrap_ptr1", sel_id_o, 1);
        tick();

        // Reset in the middle of a packet
        do_reset();
        v = 5'b00010; req = 5'b00010; set_len(1, 3);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rstmid_v_o", v_o, 0);
        chk("rstmid_yumi", yumi_o, 0);
        chk("rstmid_locked", locked_o, 0);
        chk("rstmid_sel", sel_o, 0);
        tick();
        rst = 1'b0;
        v = 5'b00101; req = 5'b00101; len_vec = '0;
        #1;
        chk("rstmid_fresh_locked", locked_o, 0);
        chk("rstmid_fresh_sel_id", sel_id_o, 0);
        chk("rstmid_fresh_yumi", yumi_o, 5'b00001);
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            v = N'($urandom);
            req = N'($urandom);
            for (int i = 0; i < N; i++)
                set_len(i, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0);
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
